calc_seq_ctrl: RTL and testbench
================================

# calc_seq_ctrl

Sequencer for the eight-bit calculator datapath. It accepts a stream of key tokens (operand, operator, equals, clear) over a valid/ready handshake. It drives the load enables and shared data bus of the A, B and result Reg8 registers, and holds the operator select for the external combinational ALU. It also supports chaining a completed result back into A.

## Interface
Parameters:
- WIDTH, 8, datapath width (operand bus, register width)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- key_valid  in  1  token offered this cycle
- key_ready  out  1  controller can accept a token; transfer = key_valid & key_ready at rising edge
- key_type  in  2  00 operand, 01 operator, 10 equals, 11 clear
- key_data  in  WIDTH  operand value (type 00); operator code in bits [1:0] (type 01); ignored otherwise
- operand_bus  out  WIDTH  registered data presented to A/B register inputs
- sel_a_src  out  1  A-input mux select: 0 = operand_bus, 1 = result register output
- en_a  out  1  load enable, operand register A
- en_b  out  1  load enable, operand register B
- en_r  out  1  load enable, result register (captures ALU output)
- alu_op  out  2  registered operator code to ALU: 00 add, 01 sub, 10 and, 11 or
- res_valid  out  1  one-cycle pulse: result register holds new value
- err  out  1  sticky sequence error
- state_dbg  out  3  current FSM state encoding

## Operation
- States: IDLE, GOT_A, GOT_OP, GOT_B, EXEC, DONE.
- Clear (type 11) has priority in every state except EXEC:
  - next state IDLE; err cleared; alu_op unchanged; no enables.
- IDLE:
  - operand: en_a with bus = data; go to GOT_A.
  - operator or equals: set err; stay.
- GOT_A:
  - operand: reload A; stay.
  - operator: latch alu_op; go to GOT_OP.
  - equals: set err; stay.
- GOT_OP:
  - operand: en_b with bus = data; go to GOT_B.
  - operator: replace alu_op; stay.
  - equals: set err; stay.
- GOT_B:
  - operand: reload B; stay.
  - equals: go to EXEC.
  - operator: set err; stay.
- EXEC (exactly one cycle): en_r = 1; key_ready = 0; next state DONE; res_valid = 1 during the first DONE cycle.
- DONE:
  - operand: new A via bus (sel_a_src = 0); go to GOT_A.
  - operator: en_a with sel_a_src = 1 (result copied to A); latch alu_op; go to GOT_OP.
  - equals: go to EXEC again (A, B and op unchanged, so the same result is recomputed; legal, no err).
- Erroneous tokens are still consumed (handshake completes). State, registers and alu_op are unchanged except err.
- err stays set until a clear token or reset.
- At most one of en_a, en_b, en_r is high in any cycle. Enables are single-cycle pulses.
- sel_a_src is 1 only in the cycle en_a is high for a chain load; otherwise 0.
- operand_bus holds its last driven value when no load is in progress.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; operand_bus 0; sel_a_src 0; en_a/en_b/en_r 0; alu_op 00; res_valid 0; err 0; key_ready 1; state_dbg = IDLE.
- Token accepted at edge k:
  - en_a/en_b and operand_bus are valid throughout cycle k+1, so the Reg8 captures at edge k+1.
  - State update is visible in cycle k+1.
- Equals accepted at edge k:
  - EXEC in cycle k+1 (en_r = 1, key_ready = 0); result captured at edge k+1.
  - DONE with res_valid = 1 in cycle k+2; key_ready = 1 again in cycle k+2.
- key_ready is 1 in every state except EXEC. Back-to-back tokens on consecutive cycles are accepted with no bubbles.
- Tokens offered during EXEC are held off (not consumed), including clear.
- rst_n asserted mid-EXEC: en_r drops immediately (asynchronously) and res_valid never pulses.

## Test plan
- Basic add: operand 0x12, operator 00, operand 0x34, equals on consecutive cycles -> en_a with bus 0x12, alu_op 00, en_b with bus 0x34, en_r for one cycle, res_valid one cycle later; result register = 0x46; err 0.
- Chaining: after 0x46 result, operator 01, operand 0x06, equals -> en_a with sel_a_src 1, then en_b bus 0x06; result = 0x40; key_ready low only in the EXEC cycle.
- Errors: from reset send equals -> err 1, state IDLE; then operator -> err stays 1; then clear -> err 0; then operand 0x05 -> en_a bus 0x05, GOT_A.
- Hold-off: key_valid held high with equals then operand 0xFF -> operand not consumed in EXEC, accepted in DONE; en_a bus 0xFF, state GOT_A.
- Reset mid-operation: deassert rst_n during EXEC -> all outputs at reset values asynchronously; res_valid never pulses; after release, operand 0x01 loads A normally.
- Replacement/repeat: operand 0x10, operand 0x20 (A reloaded), operator 10, operator 11 (op replaced), operand 0x0F, equals, equals -> alu_op 11; two en_r pulses and two res_valid pulses; result = 0x2F both times.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Token sequencer for the 8-bit calculator: drives A/B/result load enables,
// the shared operand bus and the ALU operator select from a keyed token stream.
module calc_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [1:0]       key_type,
    input  logic [WIDTH-1:0] key_data,
    output logic [WIDTH-1:0] operand_bus,
    output logic             sel_a_src,
    output logic             en_a,
    output logic             en_b,
    output logic             en_r,
    output logic [1:0]       alu_op,
    output logic             res_valid,
    output logic             err,
    output logic [2:0]       state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GOT_A = 3'd1;
    localparam logic [2:0] S_GOT_OP = 3'd2;
    localparam logic [2:0] S_GOT_B = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_OPER = 2'b01;
    localparam logic [1:0] K_EQ   = 2'b10;
    localparam logic [1:0] K_CLR  = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             sel_q, sel_d;
    logic             en_a_q, en_a_d;
    logic             en_b_q, en_b_d;
    logic [1:0]       op_q, op_d;
    logic             rv_q, rv_d;
    logic             err_q, err_d;
    logic             xfer;

    // EXEC is the only state that refuses tokens; en_r is decoded from it so
    // an asynchronous reset removes it immediately.
    assign en_r      = (state_q == S_EXEC);
    assign key_ready = ~en_r;
    assign xfer      = key_valid & key_ready;

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        sel_d   = 1'b0;
        en_a_d  = 1'b0;
        en_b_d  = 1'b0;
        op_d    = op_q;
        err_d   = err_q;
        rv_d    = (state_q == S_EXEC);
        if (state_q == S_EXEC) begin
            state_d = S_DONE;
        end else if (xfer) begin
            if (key_type == K_CLR) begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (key_type == K_OPND) begin
                            en_a_d  = 1'b1;
                            bus_d   = key_data;
                            state_d = S_GOT_A;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_GOT_A: begin
                        if (key_type == K_OPND) begin
                            en_a_d = 1'b1;
                            bus_d  = key_data;
                        end else if (key_type == K_OPER) begin
                            op_d    = key_data[1:0];
                            state_d = S_GOT_OP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_GOT_OP: begin
                        if (key_type == K_OPND) begin
                            en_b_d  = 1'b1;
                            bus_d   = key_data;
                            state_d = S_GOT_B;
                        end else if (key_type == K_OPER) begin
                            op_d = key_data[1:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_GOT_B: begin
                        if (key_type == K_OPND) begin
                            en_b_d = 1'b1;
                            bus_d  = key_data;
                        end else if (key_type == K_EQ) begin
                            state_d = S_EXEC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (key_type == K_OPND) begin
                            en_a_d  = 1'b1;
                            bus_d   = key_data;
                            state_d = S_GOT_A;
                        end else if (key_type == K_OPER) begin
                            // chain: result register feeds A, bus left alone
                            en_a_d  = 1'b1;
                            sel_d   = 1'b1;
                            op_d    = key_data[1:0];
                            state_d = S_GOT_OP;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bus_q   <= '0;
            sel_q   <= 1'b0;
            en_a_q  <= 1'b0;
            en_b_q  <= 1'b0;
            op_q    <= 2'b00;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            sel_q   <= sel_d;
            en_a_q  <= en_a_d;
            en_b_q  <= en_b_d;
            op_q    <= op_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign operand_bus = bus_q;
    assign sel_a_src   = sel_q;
    assign en_a        = en_a_q;
    assign en_b        = en_b_q;
    assign alu_op      = op_q;
    assign res_valid   = rv_q;
    assign err         = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl with a behavioural A/B/result
// register + ALU model driven by the DUT's enables.
module tb_calc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [1:0] key_type = 2'b00;
    logic [7:0] key_data = 8'h00;
    logic [7:0] operand_bus;
    logic       sel_a_src, en_a, en_b, en_r;
    logic [1:0] alu_op;
    logic       res_valid, err;
    logic [2:0] state_dbg;

    calc_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready),
        .key_type(key_type), .key_data(key_data),
        .operand_bus(operand_bus), .sel_a_src(sel_a_src),
        .en_a(en_a), .en_b(en_b), .en_r(en_r),
        .alu_op(alu_op), .res_valid(res_valid),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // external datapath model
    logic [7:0] ra = 8'h00, rb = 8'h00, rr = 8'h00;

    function automatic logic [7:0] alu(logic [7:0] a, logic [7:0] b,
                                       logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (en_a) ra <= sel_a_src ? rr : operand_bus;
        if (en_b) rb <= operand_bus;
        if (en_r) rr <= alu(ra, rb, alu_op);
    end

    typedef struct {
        int         kind;  // 0 en_a, 1 en_b, 2 en_r, 3 res_valid
        logic [7:0] val;
        logic       sel;
    } ev_t;

    ev_t q[$];

    task automatic exp_a(logic [7:0] bus, logic sel);
        q.push_back('{0, bus, sel});
    endtask
    task automatic exp_b(logic [7:0] bus);
        q.push_back('{1, bus, 1'b0});
    endtask
    task automatic exp_r(logic [1:0] op, logic [7:0] res);
        q.push_back('{2, {6'd0, op}, 1'b0});
        q.push_back('{3, res, 1'b0});
    endtask

    task automatic pop_chk(int kind, string name, int act, logic s);
        ev_t e;
        if (q.size() == 0) begin
            chk({name, "_unexpected"}, 1, 0);
            return;
        end
        e = q.pop_front();
        chk({name, "_kind"}, kind, e.kind);
        if (kind == 0) begin
            chk("en_a_sel", s, e.sel);
            if (!e.sel) chk("en_a_bus", act, e.val);
            else chk("chain_a_val", act, rr);
        end else begin
            chk({name, "_val"}, act, e.val);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (en_a) pop_chk(0, "en_a", sel_a_src ? rr : operand_bus,
                              sel_a_src);
            if (en_b) pop_chk(1, "en_b", operand_bus, 1'b0);
            if (en_r) pop_chk(2, "en_r_op", alu_op, 1'b0);
            if (res_valid) begin
                pop_chk(3, "result", rr, 1'b0);
                chk("err_at_result", err, 0);
            end
            if (en_a || en_b || en_r)
                chk("onehot_en", int'(en_a) + int'(en_b) + int'(en_r) <= 1, 1);
        end
    end

    int waited;

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(logic [1:0] t, logic [7:0] d);
        key_valid = 1'b1;
        key_type  = t;
        key_data  = d;
        waited    = 0;
        @(negedge clk);
        while (!key_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!key_ready) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_ready", key_ready, 1);
        chk("rst_state", state_dbg, 0);
        chk("rst_err", err, 0);
        chk("rst_bus", operand_bus, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_en", {en_a, en_b, en_r, sel_a_src, res_valid}, 0);
        rst_n = 1'b1;
        idle(1);

        // basic add
        exp_a(8'h12, 0);  send(2'b00, 8'h12);
        send(2'b01, 8'h00);
        chk("state_got_op", state_dbg, 2);
        exp_b(8'h34);     send(2'b00, 8'h34);
        exp_r(2'b00, 8'h46); send(2'b10, 8'h00);
        chk("exec_en_r", en_r, 1);
        chk("exec_ready", key_ready, 0);

        // chain into A, subtract
        exp_a(8'h00, 1);  send(2'b01, 8'h01);
        chk("chain_stall", waited, 1);
        exp_b(8'h06);     send(2'b00, 8'h06);
        exp_r(2'b01, 8'h40); send(2'b10, 8'h00);
        idle(3);
        chk("done_state", state_dbg, 5);
        chk("done_ready", key_ready, 1);

        // error sequence from reset
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send(2'b10, 8'h00);
        chk("err_eq_idle", err, 1);
        chk("err_state_idle", state_dbg, 0);
        send(2'b01, 8'h00);
        chk("err_sticky", err, 1);
        send(2'b11, 8'h00);
        chk("err_clear", err, 0);
        exp_a(8'h05, 0);  send(2'b00, 8'h05);
        chk("state_got_a", state_dbg, 1);

        // hold-off during EXEC
        send(2'b01, 8'h00);
        exp_b(8'h03);     send(2'b00, 8'h03);
        exp_r(2'b00, 8'h08); send(2'b10, 8'h00);
        exp_a(8'hFF, 0);  send(2'b00, 8'hFF);
        chk("holdoff_wait", waited, 1);
        chk("holdoff_state", state_dbg, 1);

        // reset during EXEC
        send(2'b01, 8'h00);
        exp_b(8'h01);     send(2'b00, 8'h01);
        send(2'b10, 8'h00);
        chk("pre_rst_en_r", en_r, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en_r", en_r, 0);
        chk("async_state", state_dbg, 0);
        chk("async_ready", key_ready, 1);
        chk("async_bus", operand_bus, 0);
        chk("async_rv", res_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("no_rv_after_rst", res_valid, 0);
        exp_a(8'h01, 0);  send(2'b00, 8'h01);
        chk("post_rst_state", state_dbg, 1);

        // replacement and repeat equals
        send(2'b11, 8'h00);
        exp_a(8'h10, 0);  send(2'b00, 8'h10);
        exp_a(8'h20, 0);  send(2'b00, 8'h20);
        send(2'b01, 8'h02);
        send(2'b01, 8'h03);
        chk("op_replaced", alu_op, 3);
        exp_b(8'h0F);     send(2'b00, 8'h0F);
        exp_r(2'b11, 8'h2F); send(2'b10, 8'h00);
        exp_r(2'b11, 8'h2F); send(2'b10, 8'h00);
        chk("repeat_stall", waited, 1);
        idle(4);
        chk("repeat_err", err, 0);
        chk("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
